// File: rtl/audio_pkg.sv
// Register map and bit positions shared by the audio sample buffer and its bench.
package audio_pkg;

    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_STATUS     = 3'd1;
    localparam logic [2:0] ADDR_DAC_LEVEL  = 3'd2;
    localparam logic [2:0] ADDR_ADC_LEVEL  = 3'd3;
    localparam logic [2:0] ADDR_DAC_THRESH = 3'd4;
    localparam logic [2:0] ADDR_ADC_THRESH = 3'd5;
    localparam logic [2:0] ADDR_DAC_DATA   = 3'd6;
    localparam logic [2:0] ADDR_ADC_DATA   = 3'd7;

    localparam int CTRL_DAC_EN     = 0;
    localparam int CTRL_ADC_EN     = 1;
    localparam int CTRL_DAC_IRQ_EN = 2;
    localparam int CTRL_ADC_IRQ_EN = 3;
    localparam int CTRL_DAC_FLUSH  = 4;
    localparam int CTRL_ADC_FLUSH  = 5;

    localparam int ST_DAC_EMPTY     = 0;
    localparam int ST_DAC_FULL      = 1;
    localparam int ST_ADC_EMPTY     = 2;
    localparam int ST_ADC_FULL      = 3;
    localparam int ST_DAC_UNDERFLOW = 4;
    localparam int ST_ADC_OVERFLOW  = 5;
    localparam int ST_DAC_IRQ       = 6;
    localparam int ST_ADC_IRQ       = 7;
    localparam int ST_DAC_WR_DROP   = 8;

    // Index of each sticky flag inside the packed sticky vector
    localparam int STICKY_UNDERFLOW = 0;
    localparam int STICKY_OVERFLOW  = 1;
    localparam int STICKY_WR_DROP   = 2;
    localparam int STICKY_N         = 3;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head shows the oldest entry combinationally.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign head    = mem[rd_ptr_reg];
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                level_reg <= level_reg + 1'b1;
            else if (do_pop && !do_push)
                level_reg <= level_reg - 1'b1;
        end
    end

endmodule

// File: rtl/avm_audio_sample_buffer.sv
// Avalon-MM register front end around the DAC and ADC sample FIFOs of the WM8731 path.
module avm_audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            avm_address,
    input  logic                  avm_read,
    input  logic                  avm_write,
    input  logic [31:0]           avm_writedata,
    output logic [31:0]           avm_readdata,
    output logic                  irq,
    input  logic                  dac_req,
    output logic [2*SAMPLE_W-1:0] dac_sample,
    output logic                  dac_valid,
    input  logic                  adc_valid,
    input  logic [2*SAMPLE_W-1:0] adc_sample
);

    localparam int W = 2 * SAMPLE_W;

    logic          dac_en_reg, adc_en_reg, dac_irq_en_reg, adc_irq_en_reg;
    logic [AW:0]   dac_thresh_reg, adc_thresh_reg;
    logic [STICKY_N-1:0] sticky_reg, sticky_set, sticky_clr;
    logic [31:0]   readdata_reg, rd_mux;
    logic [W-1:0]  dac_sample_reg;
    logic          dac_valid_reg;

    logic          wr_ctrl, wr_status, dac_flush, adc_flush;
    logic          dac_push, dac_pop, adc_push, adc_pop;
    logic [W-1:0]  dac_head, adc_head;
    logic          dac_full, dac_empty, adc_full, adc_empty;
    logic [AW:0]   dac_level, adc_level;
    logic          dac_irq, adc_irq;
    logic          unused_wdata;

    assign wr_ctrl   = avm_write && (avm_address == ADDR_CTRL);
    assign wr_status = avm_write && (avm_address == ADDR_STATUS);
    assign dac_flush = wr_ctrl & avm_writedata[CTRL_DAC_FLUSH];
    assign adc_flush = wr_ctrl & avm_writedata[CTRL_ADC_FLUSH];
    assign dac_push  = avm_write && (avm_address == ADDR_DAC_DATA);
    assign dac_pop   = dac_req & dac_en_reg & ~dac_empty;
    assign adc_push  = adc_valid & adc_en_reg;
    assign adc_pop   = avm_read && (avm_address == ADDR_ADC_DATA) && !adc_empty;
    assign unused_wdata = ^avm_writedata;

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(DEPTH), .AW(AW)) u_dac_fifo (
        .clk(clk), .rst(rst), .flush(dac_flush),
        .push(dac_push), .push_data(avm_writedata[W-1:0]), .pop(dac_pop),
        .head(dac_head), .full(dac_full), .empty(dac_empty), .level(dac_level)
    );

    sync_fifo_fwft #(.WIDTH(W), .DEPTH(DEPTH), .AW(AW)) u_adc_fifo (
        .clk(clk), .rst(rst), .flush(adc_flush),
        .push(adc_push), .push_data(adc_sample), .pop(adc_pop),
        .head(adc_head), .full(adc_full), .empty(adc_empty), .level(adc_level)
    );

    assign dac_irq = dac_irq_en_reg & (dac_level <= dac_thresh_reg);
    assign adc_irq = adc_irq_en_reg & (adc_level >= adc_thresh_reg) & ~adc_empty;
    assign irq     = dac_irq | adc_irq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dac_en_reg     <= 1'b0;
            adc_en_reg     <= 1'b0;
            dac_irq_en_reg <= 1'b0;
            adc_irq_en_reg <= 1'b0;
            dac_thresh_reg <= (AW+1)'(DEPTH / 2);
            adc_thresh_reg <= (AW+1)'(DEPTH / 2);
        end else if (avm_write) begin
            if (avm_address == ADDR_CTRL) begin
                dac_en_reg     <= avm_writedata[CTRL_DAC_EN];
                adc_en_reg     <= avm_writedata[CTRL_ADC_EN];
                dac_irq_en_reg <= avm_writedata[CTRL_DAC_IRQ_EN];
                adc_irq_en_reg <= avm_writedata[CTRL_ADC_IRQ_EN];
            end
            if (avm_address == ADDR_DAC_THRESH)
                dac_thresh_reg <= avm_writedata[AW:0];
            if (avm_address == ADDR_ADC_THRESH)
                adc_thresh_reg <= avm_writedata[AW:0];
        end
    end

    assign sticky_set[STICKY_UNDERFLOW] = dac_req & dac_en_reg & dac_empty;
    assign sticky_set[STICKY_OVERFLOW]  = adc_push & adc_full;
    assign sticky_set[STICKY_WR_DROP]   = dac_push & dac_full;
    assign sticky_clr[STICKY_UNDERFLOW] = wr_status & avm_writedata[ST_DAC_UNDERFLOW];
    assign sticky_clr[STICKY_OVERFLOW]  = wr_status & avm_writedata[ST_ADC_OVERFLOW];
    assign sticky_clr[STICKY_WR_DROP]   = wr_status & avm_writedata[ST_DAC_WR_DROP];

    // A new event in the clearing cycle keeps the flag set
    for (genvar gi = 0; gi < STICKY_N; gi++) begin : g_sticky
        always_ff @(posedge clk) begin
            if (!rst)
                sticky_reg[gi] <= 1'b0;
            else
                sticky_reg[gi] <= sticky_set[gi] | (sticky_reg[gi] & ~sticky_clr[gi]);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avm_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_DAC_EN]     = dac_en_reg;
                rd_mux[CTRL_ADC_EN]     = adc_en_reg;
                rd_mux[CTRL_DAC_IRQ_EN] = dac_irq_en_reg;
                rd_mux[CTRL_ADC_IRQ_EN] = adc_irq_en_reg;
            end
            ADDR_STATUS: begin
                rd_mux[ST_DAC_EMPTY]     = dac_empty;
                rd_mux[ST_DAC_FULL]      = dac_full;
                rd_mux[ST_ADC_EMPTY]     = adc_empty;
                rd_mux[ST_ADC_FULL]      = adc_full;
                rd_mux[ST_DAC_UNDERFLOW] = sticky_reg[STICKY_UNDERFLOW];
                rd_mux[ST_ADC_OVERFLOW]  = sticky_reg[STICKY_OVERFLOW];
                rd_mux[ST_DAC_IRQ]       = dac_irq;
                rd_mux[ST_ADC_IRQ]       = adc_irq;
                rd_mux[ST_DAC_WR_DROP]   = sticky_reg[STICKY_WR_DROP];
            end
            ADDR_DAC_LEVEL:  rd_mux = 32'(dac_level);
            ADDR_ADC_LEVEL:  rd_mux = 32'(adc_level);
            ADDR_DAC_THRESH: rd_mux = 32'(dac_thresh_reg);
            ADDR_ADC_THRESH: rd_mux = 32'(adc_thresh_reg);
            ADDR_ADC_DATA:   rd_mux = adc_empty ? 32'd0 : 32'(adc_head);
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            readdata_reg <= '0;
        else if (avm_read)
            readdata_reg <= rd_mux;
    end

    // Every request is answered; disabled or empty cases answer with silence
    always_ff @(posedge clk) begin
        if (!rst) begin
            dac_valid_reg  <= 1'b0;
            dac_sample_reg <= '0;
        end else begin
            dac_valid_reg <= dac_req;
            if (dac_req)
                dac_sample_reg <= dac_pop ? dac_head : '0;
        end
    end

    assign avm_readdata = readdata_reg;
    assign dac_sample   = dac_sample_reg;
    assign dac_valid    = dac_valid_reg;

endmodule

// File: tb/tb_avm_audio_sample_buffer.sv
// Directed bench for avm_audio_sample_buffer; expected read and DAC words go through scoreboards.
module tb_avm_audio_sample_buffer;
    import audio_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        irq;
    logic        dac_req;
    logic [31:0] dac_sample;
    logic        dac_valid;
    logic        adc_valid;
    logic [31:0] adc_sample;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q [$];
    logic [31:0] dac_q [$];

    avm_audio_sample_buffer #(.SAMPLE_W(16), .DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .irq(irq),
        .dac_req(dac_req), .dac_sample(dac_sample), .dac_valid(dac_valid),
        .adc_valid(adc_valid), .adc_sample(adc_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All drivers start and end on a falling edge
    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        avm_address = a; avm_writedata = d; avm_write = 1'b1;
        @(negedge clk);
        avm_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        avm_address = a; avm_read = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        avm_read = 1'b0;
        check(tag, avm_readdata, rd_q.pop_front());
        $display("read  addr=%0d data=0x%08h (%s)", a, avm_readdata, tag);
    endtask

    task automatic dac_pulse(input logic [31:0] exp, input string tag);
        dac_req = 1'b1;
        dac_q.push_back(exp);
        @(negedge clk);
        dac_req = 1'b0;
        check({tag, "_valid"}, 32'(dac_valid), 32'd1);
        check(tag, dac_sample, dac_q.pop_front());
        $display("dac   sample=0x%08h (%s)", dac_sample, tag);
    endtask

    task automatic adc_push(input logic [31:0] d);
        adc_valid = 1'b1; adc_sample = d;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; avm_address = '0; avm_read = 0; avm_write = 0; avm_writedata = '0;
        dac_req = 0; adc_valid = 0; adc_sample = '0;
        repeat (3) @(negedge clk);
        check("rst_readdata", avm_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_dac_valid", 32'(dac_valid), 32'd0);
        check("rst_dac_sample", dac_sample, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        cpu_read(ADDR_CTRL, 32'h0, "ctrl_reset");
        cpu_read(ADDR_STATUS, 32'h05, "status_reset");
        cpu_read(ADDR_DAC_LEVEL, 32'd0, "dac_level_reset");
        cpu_read(ADDR_ADC_LEVEL, 32'd0, "adc_level_reset");
        cpu_read(ADDR_DAC_THRESH, 32'd32, "dac_thresh_reset");
        cpu_read(ADDR_ADC_THRESH, 32'd32, "adc_thresh_reset");
        cpu_read(ADDR_DAC_DATA, 32'd0, "dac_data_read");
        cpu_read(ADDR_ADC_DATA, 32'd0, "adc_data_empty");

        // DAC fill to full, one dropped write, then drain
        cpu_write(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 64; i++) cpu_write(ADDR_DAC_DATA, 32'h1000 + i);
        cpu_write(ADDR_DAC_DATA, 32'h2000);
        cpu_read(ADDR_DAC_LEVEL, 32'd64, "dac_level_full");
        cpu_read(ADDR_STATUS, 32'h106, "status_dac_full_drop");
        for (int i = 0; i < 64; i++) dac_pulse(32'h1000 + i, "dac_drain");
        @(negedge clk);
        check("dac_valid_idle", 32'(dac_valid), 32'd0);
        check("dac_sample_hold", dac_sample, 32'h103F);

        // Underflow and W1C behaviour
        dac_pulse(32'h0, "dac_underflow_zero");
        cpu_read(ADDR_STATUS, 32'h115, "status_underflow");
        cpu_write(ADDR_STATUS, 32'h110);
        cpu_read(ADDR_STATUS, 32'h05, "status_w1c");
        avm_address = ADDR_STATUS; avm_writedata = 32'h10; avm_write = 1'b1;
        dac_req = 1'b1; dac_q.push_back(32'h0);
        @(negedge clk);
        avm_write = 1'b0; dac_req = 1'b0;
        check("dac_coincident_sample", dac_sample, dac_q.pop_front());
        cpu_read(ADDR_STATUS, 32'h15, "status_set_wins");
        cpu_write(ADDR_STATUS, 32'h10);
        cpu_read(ADDR_STATUS, 32'h05, "status_cleared");

        // Simultaneous push and pop at level 10
        for (int i = 0; i < 10; i++) cpu_write(ADDR_DAC_DATA, 32'h3000 + i);
        cpu_read(ADDR_DAC_LEVEL, 32'd10, "dac_level_10");
        avm_address = ADDR_DAC_DATA; avm_writedata = 32'h3100; avm_write = 1'b1;
        dac_req = 1'b1; dac_q.push_back(32'h3000);
        @(negedge clk);
        avm_write = 1'b0; dac_req = 1'b0;
        check("dac_simul_sample", dac_sample, dac_q.pop_front());
        cpu_read(ADDR_DAC_LEVEL, 32'd10, "dac_level_simul");
        for (int i = 1; i < 10; i++) dac_pulse(32'h3000 + i, "dac_drain2");
        dac_pulse(32'h3100, "dac_simul_pushed");
        cpu_read(ADDR_DAC_LEVEL, 32'd0, "dac_level_empty");
        cpu_write(ADDR_CTRL, 32'h5);
        check("dac_irq_low_level", 32'(irq), 32'd1);

        // ADC watermark interrupt
        cpu_write(ADDR_ADC_THRESH, 32'd4);
        cpu_write(ADDR_CTRL, 32'h0A);
        check("irq_off", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) adc_push(32'hA000 + i);
        check("adc_irq_below", 32'(irq), 32'd0);
        adc_push(32'hA003);
        check("adc_irq_at_thresh", 32'(irq), 32'd1);
        cpu_read(ADDR_ADC_DATA, 32'hA000, "adc_pop_first");
        cpu_read(ADDR_ADC_LEVEL, 32'd3, "adc_level_3");
        check("adc_irq_after_pop", 32'(irq), 32'd0);
        for (int i = 1; i < 4; i++) cpu_read(ADDR_ADC_DATA, 32'hA000 + i, "adc_pop");
        cpu_read(ADDR_ADC_LEVEL, 32'd0, "adc_level_0");

        // ADC overflow then flush racing a sample
        for (int i = 0; i < 64; i++) adc_push(32'hB000 + i);
        adc_push(32'hBFFF);
        cpu_read(ADDR_ADC_LEVEL, 32'd64, "adc_level_full");
        cpu_read(ADDR_STATUS, 32'hA9, "status_adc_overflow");
        check("adc_irq_full", 32'(irq), 32'd1);
        avm_address = ADDR_CTRL; avm_writedata = 32'h2A; avm_write = 1'b1;
        adc_valid = 1'b1; adc_sample = 32'hC000;
        @(negedge clk);
        avm_write = 1'b0; adc_valid = 1'b0;
        cpu_read(ADDR_ADC_LEVEL, 32'd0, "adc_level_flushed");
        cpu_read(ADDR_STATUS, 32'h25, "status_after_flush");
        cpu_read(ADDR_CTRL, 32'h0A, "ctrl_flush_reads_0");
        cpu_read(ADDR_ADC_DATA, 32'd0, "adc_data_after_flush");

        // Reset during an in-flight read
        avm_address = ADDR_CTRL; avm_read = 1'b1; rst = 1'b0;
        rd_q.push_back(32'd0);
        @(negedge clk);
        avm_read = 1'b0;
        check("inflight_read_reset", avm_readdata, rd_q.pop_front());
        rst = 1'b1;
        @(negedge clk);
        cpu_read(ADDR_CTRL, 32'h0, "ctrl_after_reset");
        cpu_read(ADDR_STATUS, 32'h05, "status_after_reset");
        cpu_read(ADDR_ADC_THRESH, 32'd32, "adc_thresh_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avm_audio_sample_buffer.md
# avm_audio_sample_buffer

Parametrised Avalon-MM slave that buffers stereo PCM samples between the CPU and the codec serial engine of the WM8731 audio path. It adds configurable sample width and FIFO depth, a software-visible register map with fill levels, watermark interrupts, sticky error flags and flush. It sits between the Avalon interconnect and the I2S serializer/deserializer. It replaces direct user-side FIFO ports with a CPU-driven data path.

## Interface
- SAMPLE_W, 16: bits per channel, 8..16; one FIFO word = {left, right} = 2*SAMPLE_W bits.
- DEPTH, 64: entries per FIFO, power of two, 4..1024.
- AW, $clog2(DEPTH): FIFO pointer width; levels are AW+1 bits.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-low.
- avm_address  in  3  word address.
- avm_read / avm_write  in  1  single-cycle strobes; never both asserted.
- avm_writedata  in  32  write data.
- avm_readdata  out  32  read data, registered.
- irq  out  1  level interrupt = dac_irq | adc_irq.
- dac_req  in  1  serializer requests the next stereo sample (1-cycle pulse).
- dac_sample  out  2*SAMPLE_W  sample for the serializer.
- dac_valid  out  1  1-cycle pulse; dac_sample is valid.
- adc_valid  in  1  deserializer delivers a sample (1-cycle pulse).
- adc_sample  in  2*SAMPLE_W  captured stereo sample.

## Operation
- Register map. Data is packed in bits [2*SAMPLE_W-1:0]; unused bits read 0.
  - 0 CTRL, RW: b0 dac_en, b1 adc_en, b2 dac_irq_en, b3 adc_irq_en. b4 dac_flush and b5 adc_flush are write-1 pulses and read 0.
  - 1 STATUS: R for b0 dac_empty, b1 dac_full, b2 adc_empty, b3 adc_full, b6 dac_irq, b7 adc_irq. W1C sticky flags: b4 dac_underflow, b5 adc_overflow, b8 dac_wr_drop.
  - 2 DAC_LEVEL, R. 3 ADC_LEVEL, R.
  - 4 DAC_THRESH, RW, AW+1 bits. 5 ADC_THRESH, RW, AW+1 bits.
  - 6 DAC_DATA, W: push. 7 ADC_DATA, R: pop.
- DAC push (CPU write to addr 6):
  - When not full, push writedata[2*SAMPLE_W-1:0].
  - When full, drop the data and set dac_wr_drop. A pop in the same cycle does not make room.
- DAC pop (dac_req):
  - When dac_en and not empty, pop; dac_sample = head word.
  - When dac_en and empty, dac_sample = 0 and set dac_underflow.
  - When !dac_en, dac_sample = 0, no flag, no pop.
  - dac_valid pulses in every case.
- ADC push (adc_valid):
  - When adc_en and not full, push adc_sample.
  - When adc_en and full, drop the sample and set adc_overflow.
  - When !adc_en, ignore.
- ADC pop (CPU read of addr 7):
  - When not empty, return the head word and pop.
  - When empty, return 0 with no pop and no flag.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen; level unchanged.
- Flush: resets pointers and level of that FIFO. It wins over a push or pop in the same cycle. Sticky flags are not cleared by flush.
- Interrupts:
  - dac_irq = dac_irq_en & (DAC_LEVEL <= DAC_THRESH).
  - adc_irq = adc_irq_en & (ADC_LEVEL >= ADC_THRESH) & !adc_empty.
  - Both are combinational from registered state.
- Sticky flags: a W1C in the same cycle as a new set event leaves the flag set (set wins).
- Reads of reserved addresses return 0. Writes to read-only registers are ignored.

## Timing
- Reset values:
  - avm_readdata 0, irq 0, dac_sample 0, dac_valid 0.
  - CTRL 0; both FIFOs empty.
  - DAC_THRESH = DEPTH/2, ADC_THRESH = DEPTH/2.
  - All sticky flags 0.
- Read latency is 1 cycle: avm_readdata is valid the cycle after avm_read and holds until the next read.
- ADC pop and level update commit at the clock edge ending the read cycle. A STATUS or level read on the following cycle sees the new level.
- A register write takes effect at the next edge. CTRL enables gate events starting the cycle after the write.
- dac_req at cycle N gives dac_valid and dac_sample at N+1. dac_sample holds until the next dac_req.
- adc_valid at cycle N makes the sample visible in ADC_LEVEL at N+1.
- FIFO storage may be inferred RAM; the head word must be available combinationally (FWFT) for registered readout.
- Reset mid-operation: all state returns to reset values at the next edge; in-flight reads return 0.

## Structure
- Package audio_pkg holds:
  - register address constants (ADDR_CTRL … ADDR_ADC_DATA);
  - CTRL and STATUS bit-index constants;
  - the flush/irq-enable field positions.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH) with push, pop, flush, full, empty, level and head outputs. It is instantiated twice, once for DAC and once for ADC.
- The top level holds only the register file, read mux, flag logic and codec-side handshake.

## Test plan
- Reset, then read all addresses -> CTRL 0, STATUS 0x05 (both empty), levels 0, THRESH 32, 32 (DEPTH=64).
- Set dac_en and write 64 words 0x1000+i, then write once more -> DAC_LEVEL 64, dac_full, dac_wr_drop set. 64 dac_req pulses -> dac_sample 0x1000..0x103F, each one cycle after its req.
- dac_en with empty FIFO, dac_req -> dac_sample 0 and dac_underflow set. W1C 0x10 -> cleared. W1C coincident with another underflow -> stays set.
- Set adc_en and adc_irq_en, ADC_THRESH=4, send 4 adc_valid samples -> irq high after the 4th. Read addr 7 -> first sample back, level 3, irq low.
- ADC full plus one adc_valid -> adc_overflow set, level 64. adc_flush in the same cycle as adc_valid -> level 0, adc_overflow still set.
- Simultaneous CPU DAC write and dac_req at level 10 -> level stays 10, popped word correct.
